// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and default operand width.
package mul_pkg;

    localparam int MUL_WIDTH_DEF = 8;
    localparam int CNT_W         = $clog2(MUL_WIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_add_co.sv
// WIDTH-bit carry-lookahead adder built from 4-bit CLA slices rippled slice to slice,
// with carry-in and carry-out exposed. WIDTH must be a multiple of 4.
module cla_add_co #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int NSL = WIDTH / 4;

    logic [NSL:0] c_s;

    assign c_s[0] = cin_i;

    for (genvar k = 0; k < NSL; k++) begin : g_slice
        logic [3:0] g_s;
        logic [3:0] p_s;
        logic [4:0] cc_s;

        assign g_s     = x_i[4*k +: 4] & y_i[4*k +: 4];
        assign p_s     = x_i[4*k +: 4] ^ y_i[4*k +: 4];
        assign cc_s[0] = c_s[k];
        // Fully expanded lookahead terms inside the slice.
        assign cc_s[1] = g_s[0] | (p_s[0] & cc_s[0]);
        assign cc_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cc_s[0]);
        assign cc_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                       | (p_s[2] & p_s[1] & p_s[0] & cc_s[0]);
        assign cc_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                       | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                       | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cc_s[0]);

        assign sum_o[4*k +: 4] = p_s ^ cc_s[3:0];
        assign c_s[k+1]        = cc_s[4];
    end

    assign cout_o = c_s[NSL];

endmodule

// File: rtl/seq_mul8.sv
// Sequential unsigned shift-and-add multiplier around one cla_add_co instance.
// Define ZERO_SKIP_EN to finish zero-operand requests immediately with product 0.
module seq_mul8
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH-1:0]   sum_s;
    logic               cout_s;
    logic [WIDTH-1:0]   acc_n_s;
    logic [WIDTH-1:0]   q_n_s;
    logic               zero_skip_s;

    assign addend_s = q_q[0] ? m_q : {WIDTH{1'b0}};

    cla_add_co #(.WIDTH(WIDTH)) u_add (
        .x_i    (acc_q),
        .y_i    (addend_s),
        .cin_i  (1'b0),
        .sum_o  (sum_s),
        .cout_o (cout_s)
    );

    // The carry becomes the accumulator MSB after the right shift.
    assign acc_n_s = {cout_s, sum_s[WIDTH-1:1]};
    assign q_n_s   = {sum_s[0], q_q[WIDTH-1:1]};

`ifdef ZERO_SKIP_EN
    assign zero_skip_s = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});
`else
    assign zero_skip_s = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (zero_skip_s) begin
                        product_d = {(2*WIDTH){1'b0}};
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        m_d     = a;
                        q_d     = b;
                        acc_d   = {WIDTH{1'b0}};
                        cnt_d   = {CW{1'b0}};
                        busy_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = acc_n_s;
                q_d   = q_n_s;
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    product_d = {acc_n_s, q_n_s};
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= {WIDTH{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            cnt_q     <= {CW{1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
